// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial input, control and status bundle for the PRBS checker.
interface prbs_checker_if #(parameter int CNT_WIDTH = 16);
  logic                 en;
  logic                 bit_in;
  logic                 clear;
  logic                 resync;
  logic                 locked;
  logic                 err;
  logic [CNT_WIDTH-1:0] err_count;
  modport master (output en, bit_in, clear, resync, input locked, err, err_count);
  modport slave  (input en, bit_in, clear, resync, output locked, err, err_count);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with lock/loss FSM and saturating error count.
module prbs_checker #(
  parameter int DATA_WIDTH = 4,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst_n,
  prbs_checker_if.slave bus
);
  localparam int FW = $clog2(DATA_WIDTH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_t;
  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] hist;
  logic [FW-1:0]         fill_cnt, fill_nxt;
  logic [GW-1:0]         good_cnt, good_nxt;
  logic [BW-1:0]         bad_cnt, bad_nxt;
  logic [CNT_WIDTH-1:0]  err_count, count_nxt;
  logic                  locked, err, err_nxt;
  logic                  good, fill_done, sync_done, loss;
  // an all-zero history is the LFSR lock-up state and never counts as good
  assign good      = (bus.bit_in == (hist[0] ^ hist[1])) && (|hist);
  assign fill_done = fill_cnt == FW'(DATA_WIDTH - 1);
  assign sync_done = good_cnt == GW'(LOCK_COUNT - 1);
  assign loss      = bad_cnt == BW'(LOSS_COUNT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nxt;
  always_comb begin
    state_nxt = bus.resync ? FILL :
                !bus.en ? state :
                (state == FILL && fill_done) ? SYNC :
                (state == SYNC && good && sync_done) ? LOCKED :
                (state == LOCKED && !good && loss) ? FILL : state;
  end
  always_comb begin
    fill_nxt  = bus.resync ? '0 : (bus.en && state == FILL) ? (fill_done ? '0 : fill_cnt + 1'b1) : fill_cnt;
    good_nxt  = bus.resync ? '0 : (bus.en && state == SYNC) ? ((good && !sync_done) ? good_cnt + 1'b1 : '0) : good_cnt;
    bad_nxt   = bus.resync ? '0 : (bus.en && state == LOCKED) ? ((!good && !loss) ? bad_cnt + 1'b1 : '0) : bad_cnt;
    err_nxt   = !bus.resync && bus.en && state == LOCKED && !good;
    count_nxt = bus.clear ? '0 : (err_nxt && !(&err_count)) ? err_count + 1'b1 : err_count;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist      <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      if (bus.en) hist <= {bus.bit_in, hist[DATA_WIDTH-1:1]};
      fill_cnt  <= fill_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      locked    <= state_nxt == LOCKED;
      err       <= err_nxt;
      err_count <= count_nxt;
    end
  assign bus.locked    = locked;
  assign bus.err       = err;
  assign bus.err_count = err_count;
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 4, sets the LFSR length N; the polynomial is fb = s[0]^s[1] with right shift and fb into the MSB.
REQ-002 Parameter LOCK_COUNT, default 8, is the number of consecutive good bits needed to declare lock.
REQ-003 Parameter LOSS_COUNT, default 4, is the number of consecutive bad bits needed to drop lock.
REQ-004 Parameter CNT_WIDTH, default 16, is the err_count width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  bit_in is valid this cycle; when en=0, no state, counter or history shall change.
REQ-008 bit_in  input  1  serial stream: one generator output bit (state bit 0) per valid cycle.
REQ-009 clear  input  1  synchronous clear of err_count.
REQ-010 resync  input  1  synchronous forced return to FILL.
REQ-011 locked  output  1  registered; high iff the FSM is in LOCKED.
REQ-012 err  output  1  registered one-cycle pulse per mismatched bit while LOCKED.
REQ-013 err_count  output  CNT_WIDTH  saturating count of err pulses.

Function
REQ-014 History register hist[N-1:0] shall update on each valid bit as {bit_in, hist[N-1:1]}, in every state.
REQ-015 The expected bit shall be hist[0]^hist[1], so that b[k] = b[k-N]^b[k-N+1].
REQ-016 A bit shall be "good" when bit_in==expected and hist!=0; otherwise it is "bad". The all-zero history is never good.
REQ-017 The FSM shall have three states: FILL, SYNC and LOCKED.
REQ-018 FILL: each valid bit increments fill_cnt; on the Nth valid bit the FSM shall go to SYNC with good_cnt=0 (no check is made in FILL).
REQ-019 SYNC: a good bit increments good_cnt; a bad bit clears good_cnt and the FSM stays in SYNC; the LOCK_COUNT-th consecutive good bit moves the FSM to LOCKED.
REQ-020 LOCKED: a good bit clears bad_cnt; a bad bit increments bad_cnt and raises err on the next cycle.
REQ-021 LOCKED: the LOSS_COUNT-th consecutive bad bit moves the FSM to FILL with fill_cnt=0; err still pulses for that bit.
REQ-022 Latency: locked and err shall change on the clock edge that samples the deciding bit, i.e. they are visible the cycle after that bit is presented.
REQ-023 err_count shall increment with each err and saturate at all-ones without wrapping.
REQ-024 clear shall set err_count to 0, and clear shall take priority over a same-cycle increment; the err pulse itself is unaffected.
REQ-025 resync shall move the FSM to FILL, zero fill_cnt, good_cnt and bad_cnt, and suppress err; it shall take priority over en and bit_in, and it shall not affect err_count or hist.
REQ-026 The checker shall be self-synchronising: after resync or loss of lock, no seed load is required.

Reset
REQ-027 On rst_n=0, asynchronously: state=FILL, hist=0, fill_cnt, good_cnt and bad_cnt = 0, locked=0, err=0, err_count=0.
REQ-028 Reset asserted mid-stream shall discard all progress; after release, acquisition shall restart from FILL.

Verification
REQ-029 Reset: assert rst_n=0 mid-LOCKED -> locked=0, err=0 and err_count=0 immediately, without waiting for a clock edge.
REQ-030 Clean lock, N=4: with en=1 continuously, drive the period-15 stream 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0,repeating -> locked=1 the cycle after the 12th bit (4 FILL + 8 good); err never asserts.
REQ-031 Single flip: while locked, invert one bit at position k -> err pulses for bits k, k+3 and k+4; err_count=3; locked stays 1.
REQ-032 Loss: while locked, drive 4 consecutive bits equal to ~expected -> 4 err pulses, locked=0 after the 4th bit; resuming the clean stream gives locked=1 again after 12 valid bits.
REQ-033 Gaps and zeros: toggle en randomly on the clean stream -> lock occurs after exactly 12 valid bits; an all-zero stream -> locked never rises.
REQ-034 Clear and resync: assert clear in the same cycle as a mismatch -> err=1 and err_count=0; force err_count to all-ones and add an error -> the count holds; assert resync while locked -> locked=0 next cycle.
